// File: rtl/e_digit_streamer.sv
// Streams a captured base-10000 result as ASCII: integer digits, '.', zero-padded
// fraction limbs (most significant first), then a newline carrying tx_last.
module e_digit_streamer #(
    parameter int WORDS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [16*WORDS-1:0]  in_data,
    output logic                 busy,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_last,
    output logic                 limb_err,
    output logic [2:0]           fsm_state
);

    // Byte handshake: a byte moves when tx_valid && tx_ready at a posedge. Once
    // tx_valid is raised, tx_data/tx_last/tx_valid hold until that transfer;
    // when tx_valid is low, tx_data and tx_last are zero.

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CONV      = 3'd1;
    localparam logic [2:0] SEND_INT  = 3'd2;
    localparam logic [2:0] SEND_DOT  = 3'd3;
    localparam logic [2:0] SEND_FRAC = 3'd4;
    localparam logic [2:0] SEND_NL   = 3'd5;

    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_INT      = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] IDX_FRAC_TOP = IDX_W'((WORDS > 1) ? WORDS - 2 : 0);

    logic [2:0]            state;
    logic [16*WORDS-1:0]   data_q;
    logic [IDX_W-1:0]      idx;
    logic [15:0]           rem;
    logic [1:0]            pos;
    logic [3:0]            dig [4];
    logic [1:0]            sp;
    logic                  bad_q;
    logic                  int_q;

    logic                  hs;
    logic [IDX_W-1:0]      load_idx;
    logic [15:0]           load_val;
    logic [15:0]           int_limb_in;
    logic [15:0]           cur_weight;

    function automatic logic [15:0] limb_of(input logic [16*WORDS-1:0] d,
                                            input logic [IDX_W-1:0] k);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (k == IDX_W'(i)) r = d[i*16 +: 16];
        end
        return r;
    endfunction

    function automatic logic [15:0] weight(input logic [1:0] p);
        logic [15:0] w;
        case (p)
            2'd0:    w = 16'd1000;
            2'd1:    w = 16'd100;
            2'd2:    w = 16'd10;
            default: w = 16'd1;
        endcase
        return w;
    endfunction

    // First significant digit position of the integer limb; a zero value still
    // shows its last digit.
    function automatic logic [1:0] lead_pos(input logic [3:0] d0, input logic [3:0] d1,
                                            input logic [3:0] d2);
        logic [1:0] p;
        if (d0 != 4'd0)      p = 2'd0;
        else if (d1 != 4'd0) p = 2'd1;
        else if (d2 != 4'd0) p = 2'd2;
        else                 p = 2'd3;
        return p;
    endfunction

    assign int_limb_in = in_data[16*(WORDS-1) +: 16];
    assign load_idx    = (state == SEND_DOT) ? IDX_FRAC_TOP : (idx - IDX_W'(1));
    assign load_val    = limb_of(data_q, load_idx);
    assign cur_weight  = weight(pos);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;
    assign hs          = tx_valid && tx_ready;

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        case (state)
            SEND_INT, SEND_FRAC: begin
                tx_valid = 1'b1;
                tx_data  = bad_q ? 8'h3F : (8'h30 + {4'd0, dig[sp]});
            end
            SEND_DOT: begin
                tx_valid = 1'b1;
                tx_data  = 8'h2E;
            end
            SEND_NL: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                tx_last  = 1'b1;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            idx      <= '0;
            rem      <= '0;
            pos      <= '0;
            sp       <= '0;
            bad_q    <= 1'b0;
            int_q    <= 1'b0;
            limb_err <= 1'b0;
            for (int i = 0; i < 4; i++) dig[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        idx      <= IDX_INT;
                        int_q    <= 1'b1;
                        rem      <= int_limb_in;
                        bad_q    <= (int_limb_in > 16'd9999);
                        limb_err <= (int_limb_in > 16'd9999);
                        pos      <= '0;
                        for (int i = 0; i < 4; i++) dig[i] <= '0;
                        state    <= CONV;
                    end
                end

                // One subtraction or one position step per cycle: worst case
                // 9 subtractions plus one step for each of the four positions.
                CONV: begin
                    if (bad_q || (pos == 2'd3 && rem < cur_weight)) begin
                        if (int_q) begin
                            sp    <= bad_q ? 2'd3 : lead_pos(dig[0], dig[1], dig[2]);
                            state <= SEND_INT;
                        end else begin
                            sp    <= 2'd0;
                            state <= SEND_FRAC;
                        end
                    end else if (rem >= cur_weight) begin
                        rem      <= rem - cur_weight;
                        dig[pos] <= dig[pos] + 4'd1;
                    end else begin
                        pos <= pos + 2'd1;
                    end
                end

                SEND_INT: begin
                    if (hs) begin
                        if (sp == 2'd3) state <= SEND_DOT;
                        else            sp    <= sp + 2'd1;
                    end
                end

                SEND_DOT: begin
                    if (hs) begin
                        if (WORDS == 1) begin
                            state <= SEND_NL;
                        end else begin
                            idx      <= load_idx;
                            int_q    <= 1'b0;
                            rem      <= load_val;
                            bad_q    <= (load_val > 16'd9999);
                            limb_err <= limb_err | (load_val > 16'd9999);
                            pos      <= '0;
                            for (int i = 0; i < 4; i++) dig[i] <= '0;
                            state    <= CONV;
                        end
                    end
                end

                SEND_FRAC: begin
                    if (hs) begin
                        if (sp != 2'd3) begin
                            sp <= sp + 2'd1;
                        end else if (idx == '0) begin
                            state <= SEND_NL;
                        end else begin
                            idx      <= load_idx;
                            rem      <= load_val;
                            bad_q    <= (load_val > 16'd9999);
                            limb_err <= limb_err | (load_val > 16'd9999);
                            pos      <= '0;
                            for (int i = 0; i < 4; i++) dig[i] <= '0;
                            state    <= CONV;
                        end
                    end
                end

                SEND_NL: begin
                    if (hs) state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_digit_streamer.sv
// Bench for e_digit_streamer (WORDS=4): decimal-text reference model feeds an
// expected-byte queue; a negedge monitor pops and compares every transfer.
module tb_e_digit_streamer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [16*W-1:0] in_data = '0;
  logic tx_ready = 1'b0;
  logic busy, tx_valid, tx_last, limb_err;
  logic [7:0] tx_data;
  logic [2:0] fsm_state;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [8:0] exp_q[$];
  int bytes_seen = 0;
  int ready_mode = 0;
  int pat = 0;

  always #5 clk = ~clk;

  e_digit_streamer #(.WORDS(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .limb_err(limb_err), .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: render the result as decimal text and queue its bytes.
  function automatic int model_push(input logic [16*W-1:0] d);
    int txt[$];
    int v;
    int x;
    v = int'(d[16*(W-1) +: 16]);
    if (v > 9999) txt.push_back(8'h3F);
    else begin
      x = v;
      do begin
        txt.push_front(48 + x % 10);
        x = x / 10;
      end while (x > 0);
    end
    txt.push_back(8'h2E);
    for (int i = W - 2; i >= 0; i--) begin
      v = int'(d[i*16 +: 16]);
      if (v > 9999) repeat (4) txt.push_back(8'h3F);
      else begin
        txt.push_back(48 + v / 1000);
        txt.push_back(48 + (v / 100) % 10);
        txt.push_back(48 + (v / 10) % 10);
        txt.push_back(48 + v % 10);
      end
    end
    foreach (txt[i]) exp_q.push_back({1'b0, 8'(txt[i])});
    exp_q.push_back({1'b1, 8'h0A});
    return txt.size() + 1;
  endfunction

  function automatic logic model_bad(input logic [16*W-1:0] d);
    logic b;
    b = 1'b0;
    for (int i = 0; i < W; i++) if (d[i*16 +: 16] > 16'd9999) b = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] rand_limb();
    logic [15:0] v;
    if ($urandom_range(0, 7) == 0) v = 16'($urandom_range(10000, 65535));
    else v = 16'($urandom_range(0, 9999));
    return v;
  endfunction

  // Called just after a posedge: presents one in_valid pulse.
  task automatic send(input logic [16*W-1:0] d, output int n);
    in_data = d;
    in_valid = 1'b1;
    n = model_push(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_capture", busy, 1'b1);
  endtask

  task automatic start(input logic [16*W-1:0] d, output int n);
    @(posedge clk);
    #1;
    send(d, n);
  endtask

  task automatic finish_result(input int n, input int base, input logic exp_err);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("busy_end", busy, 1'b0);
    check("byte_count", bytes_seen - base, n);
    check("limb_err", limb_err, exp_err);
  endtask

  // Sink readiness: always, 1,0,0,1 repeating, or random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = (pat == 0 || pat == 3);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      pat = (pat + 1) % 4;
    end
  end

  // Monitor: transfers, stall stability, idle zeroing.
  initial begin
    logic stall_pend;
    logic [9:0] held;
    logic [8:0] e;
    stall_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
      end else begin
        if (stall_pend) check("stall_hold", {tx_valid, tx_last, tx_data}, held);
        if (!tx_valid) check("idle_zero", {tx_last, tx_data}, 9'd0);
        if (tx_valid && tx_ready) begin
          check("byte_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("byte", {tx_last, tx_data}, e);
          end
          bytes_seen++;
        end
        stall_pend = tx_valid && !tx_ready;
        held = {tx_valid, tx_last, tx_data};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", chk_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int cyc;
    logic [16*W-1:0] d;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_last", tx_last, 1'b0);
    check("rst_limb_err", limb_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Accepted on the first cycle after reset release, sink always ready.
    ready_mode = 0;
    base = bytes_seen;
    send({16'd2, 16'd7182, 16'd8182, 16'd8459}, n);
    check("e_len_15", n, 15);
    finish_result(n, base, 1'b0);

    // Same result under the 1,0,0,1 sink pattern.
    ready_mode = 1;
    base = bytes_seen;
    start({16'd2, 16'd7182, 16'd8182, 16'd8459}, n);
    finish_result(n, base, 1'b0);

    ready_mode = 0;
    base = bytes_seen;
    start({16'd0, 16'd42, 16'd9999, 16'd1}, n);
    finish_result(n, base, 1'b0);

    base = bytes_seen;
    start({16'd123, 16'd1, 16'd20, 16'd300}, n);
    finish_result(n, base, 1'b0);

    // Out-of-range fraction limb: "????" and sticky error until next capture.
    base = bytes_seen;
    start({16'd7, 16'd1234, 16'd10000, 16'd5678}, n);
    finish_result(n, base, 1'b1);
    repeat (3) @(posedge clk);
    check("limb_err_sticky", limb_err, 1'b1);
    base = bytes_seen;
    start({16'd45, 16'd0, 16'd9, 16'd99}, n);
    check("limb_err_cleared_on_capture", limb_err, 1'b0);
    finish_result(n, base, 1'b0);

    // Out-of-range integer limb.
    base = bytes_seen;
    start({16'd65535, 16'd1, 16'd2, 16'd3}, n);
    finish_result(n, base, 1'b1);

    // Second pulse mid-stream is ignored.
    base = bytes_seen;
    start({16'd2, 16'd7182, 16'd8182, 16'd8459}, n);
    repeat (25) @(posedge clk);
    #1;
    check("busy_mid_stream", busy, 1'b1);
    in_data = {16'd9, 16'd1111, 16'd2222, 16'd3333};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    finish_result(n, base, 1'b0);

    // Reset after byte 5, then a fresh result on the first released cycle.
    base = bytes_seen;
    start({16'd2, 16'd10000, 16'd8182, 16'd8459}, n);
    cyc = 0;
    while (bytes_seen - base < 5 && cyc < 500) begin
      @(posedge clk);
      cyc++;
    end
    check("reached_byte5", bytes_seen - base, 5);
    check("err_before_rst", limb_err, 1'b1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    d = {16'd31, 16'd4159, 16'd2653, 16'd5897};
    in_data = d;
    in_valid = 1'b1;
    n = model_push(d);
    base = bytes_seen;
    @(negedge clk);
    check("rst5_busy", busy, 1'b0);
    check("rst5_tx_valid", tx_valid, 1'b0);
    check("rst5_tx_data", tx_data, 8'h00);
    check("rst5_tx_last", tx_last, 1'b0);
    check("rst5_limb_err", limb_err, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_rst_capture", busy, 1'b1);
    finish_result(n, base, 1'b0);

    // Randomized results under a random sink.
    ready_mode = 2;
    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(0, 2))
        0: d[16*(W-1) +: 16] = 16'($urandom_range(0, 9));
        1: d[16*(W-1) +: 16] = 16'($urandom_range(0, 999));
        default: d[16*(W-1) +: 16] = rand_limb();
      endcase
      for (int i = 0; i < W - 1; i++) d[i*16 +: 16] = rand_limb();
      base = bytes_seen;
      start(d, n);
      finish_result(n, base, model_bad(d));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
